// File: rtl/compare_sched_pkg.sv
// -----------------------------------------------------------------------------
// compare_sched_pkg
// Shared definitions for the compare scheduler slice: FSM state encoding and
// the default requester count / operand width.
// -----------------------------------------------------------------------------
package compare_sched_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : compare_sched_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at last_grant+1 and
// wraps around, so the most recently served requester has lowest priority.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the requester served most recently
//   grant      - one-hot grant, all-zero when no request is pending
//   grant_idx  - binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import compare_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    logic found_s;
    int   cand_s;

    // Walk the requesters in rotated order and take the first one asserting.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_s = (int'(last_grant) + off) % N_REQ;
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = IDW'(cand_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/compare_scheduler.sv
// -----------------------------------------------------------------------------
// compare_scheduler
// Accepts one compare job at a time from N_REQ requesters (round-robin), then
// compares a against b one bit per cycle, MSB first, stopping at the first
// differing bit. The result is held until the consumer takes it.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   req_valid / req_ready   - per-requester request / one-hot grant (comb.)
//   req_a, req_b            - packed operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid / rsp_ready   - result handshake
//   rsp_id                  - index of the served requester
//   rsp_less/equal/greater  - one-hot compare result
//   rsp_cycles              - number of bits evaluated (1..WIDTH)
//   busy                    - high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module compare_scheduler
    import compare_sched_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_less,
    output logic                   rsp_equal,
    output logic                   rsp_greater,
    output logic [CW-1:0]          rsp_cycles,
    output logic                   busy
);

    state_e           state_r;
    logic [IDW-1:0]   last_grant_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx_r;
    logic [IDW-1:0]   rsp_id_r;
    logic             less_r;
    logic             equal_r;
    logic             greater_r;
    logic [CW-1:0]    cycles_r;
    logic             rsp_valid_r;
    logic             busy_r;

    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [CW-1:0]    cycles_now_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // Bits evaluated so far including the current one: scan starts at WIDTH-1.
    assign cycles_now_s = CW'(WIDTH) - CW'(idx_r);

    // Grant is only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!reset && (state_r == IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM: accept, bit-serial scan with early exit, hold response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= IDW'(N_REQ - 1);
            a_r          <= '0;
            b_r          <= '0;
            idx_r        <= '0;
            rsp_id_r     <= '0;
            less_r       <= 1'b0;
            equal_r      <= 1'b0;
            greater_r    <= 1'b0;
            cycles_r     <= '0;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_valid) begin
                        a_r          <= req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
                        b_r          <= req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
                        rsp_id_r     <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        idx_r        <= IW'(WIDTH - 1);
                        less_r       <= 1'b0;
                        equal_r      <= 1'b0;
                        greater_r    <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= SCAN;
                    end
                end
                SCAN: begin
                    if (a_r[idx_r] != b_r[idx_r]) begin
                        // First differing bit from the top decides the order.
                        greater_r   <= a_r[idx_r];
                        less_r      <= b_r[idx_r];
                        cycles_r    <= cycles_now_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (idx_r == '0) begin
                        equal_r     <= 1'b1;
                        cycles_r    <= cycles_now_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        idx_r <= idx_r - IW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_less    = less_r;
    assign rsp_equal   = equal_r;
    assign rsp_greater = greater_r;
    assign rsp_cycles  = cycles_r;
    assign busy        = busy_r;

endmodule : compare_scheduler

// File: tb/tb_compare_scheduler.sv
// -----------------------------------------------------------------------------
// tb_compare_scheduler
// Directed and randomized jobs checked against a job-level reference model
// (round-robin pick, magnitude compare, highest differing bit).
// -----------------------------------------------------------------------------
module tb_compare_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  req_a;
    logic [31:0]  req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic         rsp_less;
    logic         rsp_equal;
    logic         rsp_greater;
    logic [3:0]   rsp_cycles;
    logic         busy;

    int           n_vec = 0;
    int           n_err = 0;
    int           last_g;
    logic [7:0]   a_arr [4];
    logic [7:0]   b_arr [4];

    compare_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_less    (rsp_less),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater),
        .rsp_cycles  (rsp_cycles),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Round-robin: first asserting requester after the last one served.
    function automatic int model_grant(input logic [3:0] mask);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (last_g + off) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Bits examined = distance from MSB down to the highest differing bit.
    function automatic int model_cycles(input logic [7:0] a, input logic [7:0] b);
        if (a == b) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return W - i;
        end
        return W;
    endfunction

    // {less, equal, greater}
    function automatic logic [2:0] model_res(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 3'b001;
        if (a == b) return 3'b010;
        return 3'b100;
    endfunction

    task automatic load_operands();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_res", 32'({rsp_less, rsp_equal, rsp_greater}), 32'd0);
        check_eq("rst_cycles", 32'(rsp_cycles), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        reset     = 1'b0;
        req_valid = 4'h0;
        last_g    = N - 1;
    endtask

    task automatic run_job(input logic [3:0] mask, input int hold);
        int         g;
        int         k;
        int         lat;
        logic [2:0] res;
        logic [3:0] exp_rdy;
        logic [7:0] ea;
        logic [7:0] eb;
        load_operands();
        req_valid = mask;
        rsp_ready = (hold == 0);
        #1;
        g = model_grant(mask);
        check_eq("idle_busy", 32'(busy), 32'd0);
        if (g < 0) begin
            check_eq("ready_none", 32'(req_ready), 32'd0);
            @(negedge clock);
            check_eq("stay_idle", 32'(busy), 32'd0);
            return;
        end
        exp_rdy = 4'b0001 << g;
        check_eq("grant", 32'(req_ready), 32'(exp_rdy));
        ea     = a_arr[g];
        eb     = b_arr[g];
        k      = model_cycles(ea, eb);
        res    = model_res(ea, eb);
        last_g = g;
        @(negedge clock);
        lat = 1;
        req_valid = 4'($urandom);
        while (!rsp_valid && lat < 20) begin
            check_eq("ready_scan", 32'(req_ready), 32'd0);
            @(negedge clock);
            lat++;
            req_valid = 4'($urandom);
        end
        check_eq("latency", 32'(lat), 32'(k + 1));
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_id", 32'(rsp_id), 32'(g));
        check_eq("result", 32'({rsp_less, rsp_equal, rsp_greater}), 32'(res));
        check_eq("cycles", 32'(rsp_cycles), 32'(k));
        check_eq("busy_resp", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check_eq("ready_resp", 32'(req_ready), 32'd0);
            @(negedge clock);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_id", 32'(rsp_id), 32'(g));
            check_eq("hold_res", 32'({rsp_less, rsp_equal, rsp_greater}), 32'(res));
            check_eq("hold_cycles", 32'(rsp_cycles), 32'(k));
            req_valid = 4'($urandom);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("post_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 4'h0;
    endtask

    initial begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 8'h00;
            b_arr[i] = 8'h00;
        end
        do_reset();

        // Greater decided on the MSB, then full-length equal, then less on bit 0.
        a_arr[0] = 8'h80; b_arr[0] = 8'h7F;
        run_job(4'b0001, 0);
        a_arr[2] = 8'h5A; b_arr[2] = 8'h5A;
        run_job(4'b0100, 0);
        a_arr[1] = 8'h12; b_arr[1] = 8'h13;
        run_job(4'b0010, 0);

        // All requesters pending with consumer always ready: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
        end
        for (int j = 0; j < 5; j++) run_job(4'hF, 0);

        // Consumer stalls for 5 cycles.
        a_arr[1] = 8'h40; b_arr[1] = 8'h44;
        run_job(4'b0010, 5);

        // Randomized jobs with varying masks, operands and back-pressure.
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < N; i++) begin
                a_arr[i] = 8'($urandom);
                case ($urandom_range(0, 2))
                    0:       b_arr[i] = a_arr[i];
                    1:       b_arr[i] = a_arr[i] ^ (8'h01 << $urandom_range(0, 7));
                    default: b_arr[i] = 8'($urandom);
                endcase
            end
            run_job(4'($urandom), $urandom_range(0, 3));
        end

        // Reset during SCAN of a req3 job abandons it; priority restarts at 0.
        do_reset();
        a_arr[0] = 8'h01; b_arr[0] = 8'h02;
        run_job(4'b0001, 0);
        run_job(4'b0010, 0);
        run_job(4'b0100, 0);
        a_arr[3] = 8'h3C; b_arr[3] = 8'h3C;
        load_operands();
        req_valid = 4'b1000;
        #1;
        check_eq("grant_r3", 32'(req_ready), 32'h8);
        @(negedge clock);
        check_eq("scan_busy", 32'(busy), 32'd1);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 4'hF;
        @(negedge clock);
        check_eq("rst_scan_ready", 32'(req_ready), 32'd0);
        check_eq("rst_scan_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_scan_busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        req_valid = 4'h0;
        last_g    = N - 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check_eq("no_rsp", 32'(rsp_valid), 32'd0);
        end
        a_arr[0] = 8'hAA; b_arr[0] = 8'hAB;
        run_job(4'b1001, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_compare_scheduler

// File: doc/compare_scheduler.md
COMPARE_SCHEDULER -- requirements
Module: compare_scheduler

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; WIDTH, default 8, operand width in bits.
REQ-002 Port clock SHALL be: input, 1 bit, the single clock for all state.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high.
REQ-004 Port req_valid SHALL be: input, N_REQ bits, per-requester compare request.
REQ-005 Port req_ready SHALL be: output, N_REQ bits, one-hot grant or all-zero.
REQ-006 Ports req_a and req_b SHALL each be: input, N_REQ*WIDTH bits; requester k's operand is at [k*WIDTH +: WIDTH].
REQ-007 Port rsp_valid SHALL be: output, 1 bit, result available.
REQ-008 Port rsp_ready SHALL be: input, 1 bit, consumer accepts the result.
REQ-009 Port rsp_id SHALL be: output, clog2(N_REQ) bits, index of the served requester.
REQ-010 Ports rsp_less, rsp_equal and rsp_greater SHALL each be: output, 1 bit, one-hot result of a versus b.
REQ-011 Port rsp_cycles SHALL be: output, clog2(WIDTH)+1 bits, number of bit evaluations used (range 1..WIDTH).
REQ-012 Port busy SHALL be: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and RESP.
REQ-014 In IDLE with any req_valid set, the arbiter SHALL grant round-robin, searching from last_grant+1 upward with wrap-around.
REQ-015 req_ready[g] SHALL be combinational, high only in IDLE and only for the granted g.
REQ-016 On the accept edge the block SHALL capture req_a[g], req_b[g] and g, set bit index to WIDTH-1, update last_grant to g, and enter SCAN.
REQ-017 In SCAN the block SHALL evaluate exactly one bit per cycle, MSB first; bits below the deciding bit SHALL NOT be evaluated (early termination).
REQ-018 For a differing bit, the SCAN cycle SHALL set rsp_greater=a[idx] and rsp_less=b[idx], then enter RESP.
REQ-019 For an equal bit with idx==0, the SCAN cycle SHALL set rsp_equal=1, then enter RESP.
REQ-020 For an equal bit with idx>0, the SCAN cycle SHALL decrement idx and remain in SCAN.
REQ-021 Latency SHALL be: accept edge t, first SCAN cycle t+1, rsp_valid high at t+1+k where k = bits evaluated.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_id, result bits and rsp_cycles SHALL be held stable until rsp_valid&&rsp_ready.
REQ-023 The rsp_valid&&rsp_ready handshake SHALL return the FSM to IDLE.
REQ-024 No request SHALL be accepted in SCAN or RESP, and none in the handshake cycle (at least one IDLE cycle between jobs).
REQ-025 Result bits SHALL be exactly one-hot whenever rsp_valid=1.
REQ-026 A requester dropping req_valid before grant SHALL NOT be granted; requests are never queued internally.

Reset
REQ-027 On reset the FSM SHALL go to IDLE, with rsp_valid, the result bits, rsp_cycles, rsp_id and busy all 0.
REQ-028 Reset SHALL make last_grant = N_REQ-1, so requester 0 has first priority.
REQ-029 req_ready SHALL be all-zero while reset=1.
REQ-030 Reset in SCAN or RESP SHALL abandon the job with no response issued; captured operands are don't-care.

Structure
REQ-031 Package compare_sched_pkg SHALL hold the state encoding (IDLE/SCAN/RESP) and the default N_REQ and WIDTH constants.
REQ-032 Sub-module rr_arbiter (inputs: request vector and last_grant; outputs: one-hot grant and index) SHALL be purely combinational; all state SHALL stay in compare_scheduler.

Verification (WIDTH=8, N_REQ=4)
REQ-033 Scenario: req0 with a=0x80, b=0x7F -> rsp_greater=1, rsp_cycles=1, rsp_id=0, rsp_valid at accept+2.
REQ-034 Scenario: req2 with a=b=0x5A -> rsp_equal=1, rsp_cycles=8, rsp_id=2, rsp_valid at accept+9.
REQ-035 Scenario: req1 with a=0x12, b=0x13 -> rsp_less=1, rsp_cycles=8.
REQ-036 Scenario: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; never two req_ready bits high at once.
REQ-037 Scenario: rsp_ready held low for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; IDLE the cycle after rsp_ready rises.
REQ-038 Scenario: reset pulsed in SCAN after req3 was granted -> rsp_valid=0; the next simultaneous req0+req3 grants req0.
